data_ram_moc: RTL and testbench
===============================

// Module: data_ram_moc
// PURPOSE
//  Data memory for the ARM simulator datapath, with a memory-operation handshake.
//  Consumes the control unit's Moore memory strobes: MFA (memory function active), RW and DataSize.
//  Returns MOC (memory operation complete), which feeds the control unit's MOC input.
//  Wait states let the microcode's "wait for MOC" states (e.g. STRB final state) be exercised.
//  Supports byte, halfword and word accesses, big-endian.
// PARAMETERS
//  ADDR_WIDTH   8   byte-address width; memory depth = 2**ADDR_WIDTH bytes
//  WAIT_CYCLES  2   clock edges from request capture to MOC assertion; legal range 1..15
// PORTS
//  Clk       in   1   clock, all state updates on posedge
//  reset     in   1   synchronous, active-high
//  MFA       in   1   memory function active (request strobe from control register)
//  RW        in   1   1 = read, 0 = write
//  DataSize  in   2   00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
//  Address   in   ADDR_WIDTH   byte address from MAR
//  DataIn    in   32  write data from MDR
//  DataOut   out  32  read data to MDR
//  MOC       out  1   memory operation complete
// BEHAVIOUR
//  Reset (reset=1 at posedge)
//   - state <= IDLE, MOC <= 0, DataOut <= 0, wait counter <= 0.
//   - Memory array contents are NOT cleared by reset; power-up contents are undefined.
//   - Reset mid-operation abandons the access: no write is committed and MOC never rises.
//   - Reset has priority over every other condition.
//  FSM states: IDLE, BUSY, DONE
//   IDLE
//    - MFA=1 at edge E0: latch Address, RW, DataSize and DataIn; cnt <= 0; go to BUSY.
//    - MFA=0: stay in IDLE.
//   BUSY
//    - Each edge with cnt != WAIT_CYCLES-1: cnt <= cnt+1.
//    - Edge with cnt == WAIT_CYCLES-1: perform the access, MOC <= 1, go to DONE.
//    - Result: MOC is visible after edge E0+WAIT_CYCLES (WAIT_CYCLES=1 gives MOC one edge after E0).
//    - Changes on MFA, Address, RW or DataIn during BUSY are ignored; only latched values are used.
//   DONE
//    - MOC held at 1 and DataOut held.
//    - MFA=0 at an edge: MOC <= 0, go to IDLE (four-phase handshake).
//    - MFA still 1: stay in DONE. A new request needs MFA low for at least one edge.
//  Access rules (big-endian, using latched values; A = latched address)
//   - Word: low 2 address bits forced to 0; mem[A]=bits 31:24, A+1=23:16, A+2=15:8, A+3=7:0.
//   - Halfword: bit 0 forced to 0; mem[A]=bits 15:8, A+1=7:0.
//     Read zero-extends to 32 bits; write stores DataIn[15:0].
//   - Byte: read gives {24'b0, mem[A]}; write stores DataIn[7:0] only.
//   - Byte lanes not addressed by a write are unchanged.
//   - A write commits on the BUSY->DONE edge and never changes DataOut.
//   - A read updates DataOut on the BUSY->DONE edge; DataOut then holds until the next read completes.
//   - Address arithmetic wraps modulo 2**ADDR_WIDTH; aligned accesses never wrap.
// TESTING
//  1. Reset: hold reset 2 edges -> MOC=0, DataOut=0, state IDLE; MFA=1 during reset starts no access.
//  2. Word write then read (WAIT_CYCLES=2):
//     - Write 0xAABBCCDD at addr 0x04; MOC rises exactly 2 edges after MFA is sampled.
//     - Drop MFA -> MOC=0 on the next edge.
//     - Read 0x04 -> DataOut=0xAABBCCDD.
//  3. Byte and halfword lanes, starting from word 0xAABBCCDD at 0x04:
//     - STRB 0x11 at addr 0x06; word read at 0x04 -> 0xAABB11DD.
//     - Byte read at 0x05 -> 0x000000BB; halfword read at 0x07 (aligned to 0x06) -> 0x000011DD.
//  4. Handshake hold: keep MFA=1 for 5 edges after MOC -> MOC stays 1 and no second access occurs.
//     Then drop MFA for 1 edge and raise it again -> a new access completes.
//  5. Reset mid-op: start a word write of 0xFFFFFFFF at 0x08, assert reset while in BUSY
//     -> MOC never rises and a later read of 0x08 returns the prior contents.
//  6. Latch check: change Address and DataIn during BUSY -> the write lands at the originally latched address.

Source files
------------

// File: rtl/data_ram_moc_if.sv
// rtl/data_ram_moc_if.sv - memory-operation handshake bus between control unit and data RAM
//
// Purpose: groups the MFA/MOC handshake and the address/data bus of the data RAM.
// Signals:
//   MFA       master->slave  memory function active (request strobe)
//   RW        master->slave  1 = read, 0 = write
//   DataSize  master->slave  00 byte, 01 halfword, 10/11 word
//   Address   master->slave  byte address
//   DataIn    master->slave  write data
//   DataOut   slave->master  read data
//   MOC       slave->master  memory operation complete
interface data_ram_moc_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  MFA;
  logic                  RW;
  logic [1:0]            DataSize;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           DataIn;
  logic [31:0]           DataOut;
  logic                  MOC;

  modport master (
    output MFA, RW, DataSize, Address, DataIn,
    input  DataOut, MOC
  );

  modport slave (
    input  MFA, RW, DataSize, Address, DataIn,
    output DataOut, MOC
  );
endinterface

// File: rtl/data_ram_moc.sv
// rtl/data_ram_moc.sv - big-endian data RAM with MFA/MOC four-phase handshake and wait states
//
// Purpose: data memory for the ARM simulator datapath. A request is captured when MFA
// is high in IDLE, the access is performed WAIT_CYCLES edges later, MOC is raised and
// held until MFA drops.
// Ports:
//   Clk    in  clock, all state updates on posedge
//   reset  in  synchronous, active-high
//   bus    slave modport of data_ram_moc_if (MFA, RW, DataSize, Address, DataIn in;
//          DataOut, MOC out)
module data_ram_moc #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           Clk,
  input  logic           reset,
  data_ram_moc_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           dout_q, dout_d;
  logic                  moc_q, moc_d;

  logic [7:0]            mem [DEPTH];

  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [7:0]            lane_rd [4];
  logic [7:0]            lane_wr [4];
  logic [3:0]            lane_en;
  logic [3:0]            mem_we;
  logic [31:0]           rd_data;
  logic                  access_fire;

  // Alignment: halfword clears bit 0, word (and reserved size) clears bits 1:0.
  always_comb begin
    base_addr = addr_q;
    case (size_q)
      2'b00:   base_addr = addr_q;
      2'b01:   base_addr[0] = 1'b0;
      default: base_addr[1:0] = 2'b00;
    endcase
  end

  // Lane i is the byte at base+i; lane 0 is the most significant (big-endian).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = base_addr + ADDR_WIDTH'(i);
      lane_rd[i]   = mem[lane_addr[i]];
    end
  end

  // Read data assembly and write lane steering, all from latched request values.
  always_comb begin
    rd_data = 32'h0;
    lane_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane_wr[i] = 8'h00;
    end
    case (size_q)
      2'b00: begin
        rd_data    = {24'h0, lane_rd[0]};
        lane_wr[0] = din_q[7:0];
        lane_en    = 4'b0001;
      end
      2'b01: begin
        rd_data    = {16'h0, lane_rd[0], lane_rd[1]};
        lane_wr[0] = din_q[15:8];
        lane_wr[1] = din_q[7:0];
        lane_en    = 4'b0011;
      end
      default: begin
        rd_data    = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
        lane_wr[0] = din_q[31:24];
        lane_wr[1] = din_q[23:16];
        lane_wr[2] = din_q[15:8];
        lane_wr[3] = din_q[7:0];
        lane_en    = 4'b1111;
      end
    endcase
  end

  assign access_fire = (state_q == BUSY) && (cnt_q == LAST_CNT);

  // Reset abandons an in-flight write: nothing is committed on a reset edge.
  assign mem_we = lane_en & {4{access_fire && !rw_q && !reset}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = moc_q;

    case (state_q)
      IDLE: begin
        if (bus.MFA) begin
          addr_d  = bus.Address;
          rw_d    = bus.RW;
          size_d  = bus.DataSize;
          din_d   = bus.DataIn;
          cnt_d   = 4'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (access_fire) begin
          moc_d   = 1'b1;
          state_d = DONE;
          if (rw_q) begin
            dout_d = rd_data;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // Four-phase: MOC stays up until the requester withdraws MFA.
        if (!bus.MFA) begin
          moc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        moc_d   = 1'b0;
      end
    endcase

    if (reset) begin
      state_d = IDLE;
      moc_d   = 1'b0;
      dout_d  = 32'h0;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge Clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    rw_q    <= rw_d;
    size_q  <= size_d;
    din_q   <= din_d;
    dout_q  <= dout_d;
    moc_q   <= moc_d;
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) begin
        mem[lane_addr[i]] <= lane_wr[i];
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;

endmodule

// File: tb/tb_data_ram_moc.sv
// tb/tb_data_ram_moc.sv - scoreboard bench for data_ram_moc with randomized accesses
module tb_data_ram_moc;

  localparam int AW    = 8;
  localparam int WAITC = 2;

  logic Clk;
  logic reset;

  data_ram_moc_if #(.ADDR_WIDTH(AW)) bus ();

  data_ram_moc #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  m [256];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] exp_q [$];
  logic        moc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access touches 1, 2 or 4 consecutive bytes starting at the
  // address rounded down to a multiple of that count; the first byte is most significant.
  function automatic logic [31:0] model_access(input bit rw, input logic [1:0] sz,
                                               input logic [7:0] a, input logic [31:0] d);
    int          n;
    int          base;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a) - (int'(a) % n);
    v    = 32'h0;
    if (rw) begin
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(m[base + i]);
      last_rd = v;
    end else begin
      for (int i = 0; i < n; i++) m[base + i] = 8'(d >> (8 * (n - 1 - i)));
    end
    return last_rd;
  endfunction

  // Monitor: every rising MOC is one completed access; DataOut is checked against the queue.
  always @(negedge Clk) begin
    if (bus.MOC && !moc_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_moc", 32'(bus.MOC), 32'h0);
      end else begin
        check("dataout", bus.DataOut, exp_q.pop_front());
      end
    end
    moc_prev = bus.MOC;
  end

  task automatic access(input bit rw, input logic [1:0] sz, input logic [7:0] a,
                        input logic [31:0] d, input bit scramble, input int hold);
    int lat;
    exp_q.push_back(model_access(rw, sz, a, d));
    @(negedge Clk);
    bus.MFA      = 1'b1;
    bus.RW       = rw;
    bus.DataSize = sz;
    bus.Address  = a;
    bus.DataIn   = d;
    @(posedge Clk);
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk);
      lat++;
      #1;
      if (bus.MOC) break;
      if (scramble) begin
        bus.Address = 8'($urandom);
        bus.DataIn  = $urandom;
        bus.RW      = 1'($urandom);
      end
    end
    check("moc_latency", 32'(lat), 32'(WAITC));
    repeat (hold) begin
      @(posedge Clk);
      #1;
      check("moc_hold", 32'(bus.MOC), 32'h1);
    end
    @(negedge Clk);
    bus.MFA = 1'b0;
    @(posedge Clk);
    #1;
    check("moc_drop", 32'(bus.MOC), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.MFA      = 1'b1;
    bus.RW       = 1'b0;
    bus.DataSize = 2'b10;
    bus.Address  = 8'h00;
    bus.DataIn   = 32'hFFFF_FFFF;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_moc", 32'(bus.MOC), 32'h0);
    check("reset_dataout", bus.DataOut, 32'h0);
    @(negedge Clk);
    bus.MFA = 1'b0;
    reset   = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      #1;
      check("idle_moc", 32'(bus.MOC), 32'h0);
    end

    for (int w = 0; w < 64; w++) access(1'b0, 2'b10, 8'(w * 4), $urandom, 1'b0, 0);

    access(1'b0, 2'b10, 8'h04, 32'hAABBCCDD, 1'b0, 0);
    access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 0);
    access(1'b0, 2'b00, 8'h06, 32'hDEAD_BE11, 1'b0, 0);
    access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 0);
    access(1'b1, 2'b00, 8'h05, 32'h0, 1'b0, 0);
    access(1'b1, 2'b01, 8'h07, 32'h0, 1'b0, 0);
    access(1'b1, 2'b01, 8'h06, 32'h0, 1'b0, 5);
    access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 0);
    check("directed_model", last_rd, 32'hAABB11DD);
    access(1'b0, 2'b11, 8'hFF, 32'h0102_0304, 1'b0, 1);
    access(1'b1, 2'b00, 8'hFC, 32'h0, 1'b0, 0);

    // Reset while BUSY: write must not land and MOC must not rise.
    @(negedge Clk);
    bus.MFA      = 1'b1;
    bus.RW       = 1'b0;
    bus.DataSize = 2'b10;
    bus.Address  = 8'h08;
    bus.DataIn   = 32'hFFFF_FFFF;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("busy_moc", 32'(bus.MOC), 32'h0);
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midop_moc", 32'(bus.MOC), 32'h0);
    check("midop_dataout", bus.DataOut, 32'h0);
    @(negedge Clk);
    reset   = 1'b0;
    bus.MFA = 1'b0;
    last_rd = 32'h0;
    repeat (4) begin
      @(posedge Clk);
      #1;
      check("post_reset_moc", 32'(bus.MOC), 32'h0);
    end
    access(1'b1, 2'b10, 8'h08, 32'h0, 1'b0, 0);

    // Inputs scrambled during BUSY must be ignored.
    access(1'b0, 2'b10, 8'h10, 32'h1234_5678, 1'b1, 0);
    access(1'b1, 2'b10, 8'h10, 32'h0, 1'b1, 0);

    for (int k = 0; k < 300; k++) begin
      access(1'($urandom), 2'($urandom), 8'($urandom), $urandom,
             1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int w = 0; w < 64; w++) access(1'b1, 2'b10, 8'(w * 4), 32'h0, 1'b0, 0);

    repeat (2) @(posedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
